// File: rtl/sfu_pkg.sv
// Shared types and arithmetic helpers for the SFU accumulation stage:
// FSM state encoding and signed saturation from accumulator to psum width.
package sfu_pkg;

  localparam int PSUM_BW = 16;
  localparam int ACC_BW  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Values fit when every bit from the psum sign bit upward agrees.
  function automatic logic signed [PSUM_BW-1:0] saturate(input logic signed [ACC_BW-1:0] v);
    logic [ACC_BW-PSUM_BW:0] top;
    top = v[ACC_BW-1:PSUM_BW-1];
    if (top == '0 || top == '1) return v[PSUM_BW-1:0];
    else if (v[ACC_BW-1])       return {1'b1, {(PSUM_BW-1){1'b0}}};
    else                        return {1'b0, {(PSUM_BW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/sfu_accum_if.sv
// Config, psum input stream, result output stream and status of sfu_accum.
interface sfu_accum_if #(
  parameter int psum_bw = 16,
  parameter int pass_bw = 4
);
  logic               cfg_start;
  logic [pass_bw-1:0] cfg_passes;
  logic               cfg_relu;
  logic               in_valid;
  logic               in_ready;
  logic [psum_bw-1:0] in_psum;
  logic               out_valid;
  logic               out_ready;
  logic [psum_bw-1:0] out_data;
  logic               busy;
  logic               done;

  modport master (
    output cfg_start, cfg_passes, cfg_relu, in_valid, in_psum, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  cfg_start, cfg_passes, cfg_relu, in_valid, in_psum, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/psum_sat_relu.sv
// Drain-path post-processing: saturate the accumulator to psum width, then
// optionally clamp negative results to zero.
module psum_sat_relu
  import sfu_pkg::*;
#(
  parameter int acc_bw  = ACC_BW,
  parameter int psum_bw = PSUM_BW
) (
  input  logic signed [acc_bw-1:0]  in,
  input  logic                      relu,
  output logic signed [psum_bw-1:0] out
);

  logic signed [psum_bw-1:0] sat;

  always_comb begin
    sat = saturate(in);
    out = (relu && sat[psum_bw-1]) ? '0 : sat;
  end

endmodule

// File: rtl/sfu_accum.sv
// Accumulates K passes of column psums into a depth-entry register file, then
// drains saturated (optionally ReLU'd) results in index order.
module sfu_accum
  import sfu_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int acc_bw  = 20,
  parameter int depth   = 16,
  parameter int addr_bw = 4,
  parameter int pass_bw = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  sfu_accum_if.slave bus
);

  localparam logic [addr_bw-1:0] IDX_LAST = addr_bw'(depth - 1);

  state_t             state_q, state_d;
  logic [addr_bw-1:0] idx_q, idx_d;
  logic [pass_bw-1:0] pass_q, pass_d;
  logic [pass_bw-1:0] k_last_q, k_last_d;
  logic               relu_q, relu_d;
  logic               done_q, done_d;
  logic               wr_en;
  logic               in_hs, out_hs;

  logic signed [acc_bw-1:0]  acc_mem [depth];
  logic signed [acc_bw-1:0]  psum_ext;
  logic signed [psum_bw-1:0] post;

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.out_data  = bus.out_valid ? post : '0;

  assign in_hs    = bus.in_valid  && (state_q == ACCUM);
  assign out_hs   = bus.out_ready && (state_q == DRAIN);
  assign psum_ext = {{(acc_bw-psum_bw){bus.in_psum[psum_bw-1]}}, bus.in_psum};

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    k_last_d = k_last_q;
    relu_d   = relu_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.cfg_start) begin
        state_d  = ACCUM;
        idx_d    = '0;
        pass_d   = '0;
        k_last_d = (bus.cfg_passes == '0) ? '0 : bus.cfg_passes - 1'b1;
        relu_d   = bus.cfg_relu;
      end
      ACCUM: if (in_hs) begin
        wr_en = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          if (pass_q == k_last_q) state_d = DRAIN;
          else                    pass_d  = pass_q + 1'b1;
        end
      end
      DRAIN: if (out_hs) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      pass_q   <= '0;
      k_last_q <= '0;
      relu_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      k_last_q <= k_last_d;
      relu_q   <= relu_d;
      done_q   <= done_d;
    end
  end

  // NOTE: the array is deliberately not reset; the first pass overwrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) acc_mem[idx_q] <= (pass_q == '0) ? psum_ext : acc_mem[idx_q] + psum_ext;
  end

  psum_sat_relu #(
    .acc_bw (acc_bw),
    .psum_bw(psum_bw)
  ) u_post (
    .in  (acc_mem[idx_q]),
    .relu(relu_q),
    .out (post)
  );

endmodule

// File: tb/tb_sfu_accum.sv
// Directed bench for sfu_accum: one task per scenario, hand-computed expectations.
module tb_sfu_accum;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sfu_accum_if #(.psum_bw(16), .pass_bw(4)) bus ();

  sfu_accum dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] got_q [16];
  int          got_n;
  int          held_bad;
  int          done_during;
  logic        done_at_end;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] k, input logic relu);
    bus.cfg_passes = k;
    bus.cfg_relu   = relu;
    bus.cfg_start  = 1'b1;
    step();
    bus.cfg_start  = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v, input int gap);
    bit sent = 0;
    bus.in_valid = 1'b0;
    repeat (gap) step();
    bus.in_valid = 1'b1;
    bus.in_psum  = v;
    for (int t = 0; t < 100 && !sent; t++) begin
      if (bus.in_ready === 1'b1) sent = 1;
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  // Collects drained results; mode 1 toggles out_ready 1,0,0,...
  task automatic drain(input int mode, input int pulse_at);
    logic [15:0] held = '0;
    bit stalled = 0;
    got_n = 0; held_bad = 0; done_during = 0;
    for (int cyc = 0; cyc < 300 && got_n < 16; cyc++) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      bus.cfg_start = (cyc == pulse_at);
      if (bus.done === 1'b1) done_during++;
      if (bus.out_valid === 1'b1) begin
        if (stalled && bus.out_data !== held) held_bad++;
        held    = bus.out_data;
        stalled = !bus.out_ready;
        if (bus.out_ready) begin
          got_q[got_n] = bus.out_data;
          got_n++;
        end
      end
      step();
    end
    bus.cfg_start = 1'b0;
    bus.out_ready = 1'b0;
    done_at_end = (bus.done === 1'b1) && (bus.busy === 1'b0);
  endtask

  task automatic test_reset();
    bus.cfg_start = 0; bus.cfg_passes = 0; bus.cfg_relu = 0;
    bus.in_valid = 0; bus.in_psum = 0; bus.out_ready = 0;
    repeat (3) step();
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {bus.in_ready, bus.out_valid, bus.busy, bus.done});
    end
    n_checks++;
    if (bus.out_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h expected 0000", bus.out_data);
    end
    reset_n = 1'b1;
    bus.in_valid = 1'b1;
    step();
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_accept: in_ready=%b busy=%b expected 0 0", bus.in_ready, bus.busy);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] e;
    start_run(4'd1, 1'b0);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_after_start: got %b expected 1", bus.in_ready);
    end
    for (int i = 0; i < 16; i++) feed(16'(-3 * i), 0);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_out_valid: got %b expected 1", bus.out_valid);
    end
    drain(0, -1);
    n_checks++;
    if (got_n !== 16) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected 16", got_n);
    end
    for (int i = 0; i < 16; i++) begin
      e = 16'(-3 * i);
      n_checks++;
      if (got_q[i] !== e) begin
        n_fail++;
        $display("FAIL basic_out[%0d]: got %0d expected %0d", i, $signed(got_q[i]), $signed(e));
      end
    end
    n_checks++;
    if (!done_at_end || done_during !== 0) begin
      n_fail++;
      $display("FAIL basic_done: at_end=%b early=%0d expected 1 0", done_at_end, done_during);
    end
    step();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_multi_pass();
    start_run(4'd3, 1'b0);
    for (int i = 0; i < 48; i++) feed(16'd100, 0);
    drain(0, -1);
    n_checks++;
    if (got_n !== 16) begin
      n_fail++;
      $display("FAIL k3_count: got %0d expected 16", got_n);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (got_q[i] !== 16'd300) begin
        n_fail++;
        $display("FAIL k3_out[%0d]: got %0d expected 300", i, $signed(got_q[i]));
      end
    end
    n_checks++;
    if (!done_at_end) begin
      n_fail++;
      $display("FAIL k3_done: got %b expected 1", done_at_end);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_v [3];
    logic [3:0]  ks    [3];
    logic [15:0] ins   [3];
    logic        relus [3];
    exp_v = '{16'h7FFF, 16'h8000, 16'h0000};
    ks    = '{4'd4, 4'd2, 4'd2};
    ins   = '{16'h7FFF, 16'h8000, 16'h8000};
    relus = '{1'b0, 1'b0, 1'b1};
    for (int r = 0; r < 3; r++) begin
      start_run(ks[r], relus[r]);
      for (int i = 0; i < 16 * int'(ks[r]); i++) feed(ins[r], 0);
      drain(0, -1);
      n_checks++;
      if (got_n !== 16) begin
        n_fail++;
        $display("FAIL sat%0d_count: got %0d expected 16", r, got_n);
      end
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (got_q[i] !== exp_v[r]) begin
          n_fail++;
          $display("FAIL sat%0d_out[%0d]: got %h expected %h", r, i, got_q[i], exp_v[r]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    start_run(4'd2, 1'b0);
    for (int i = 0; i < 16; i++) feed(16'(11 * i), ((i % 4) == 2) ? 3 : 0);
    for (int i = 0; i < 16; i++) feed(16'(-i), ((i % 5) == 1) ? 2 : 0);
    drain(1, -1);
    n_checks++;
    if (got_n !== 16) begin
      n_fail++;
      $display("FAIL bp_count: got %0d expected 16", got_n);
    end
    for (int i = 0; i < 16; i++) begin
      e = 16'(10 * i);
      n_checks++;
      if (got_q[i] !== e) begin
        n_fail++;
        $display("FAIL bp_out[%0d]: got %0d expected %0d", i, $signed(got_q[i]), $signed(e));
      end
    end
    n_checks++;
    if (held_bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d changes while stalled expected 0", held_bad);
    end
  endtask

  task automatic test_reset_mid();
    start_run(4'd2, 1'b0);
    for (int i = 0; i < 5; i++) feed(16'h1234, 0);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b in_ready=%b expected 0 0", bus.busy, bus.in_ready);
    end
    step();
    reset_n = 1'b1;
    step();
    start_run(4'd1, 1'b0);
    for (int i = 0; i < 16; i++) feed(16'(i), 0);
    drain(0, -1);
    n_checks++;
    if (got_n !== 16) begin
      n_fail++;
      $display("FAIL restart_count: got %0d expected 16", got_n);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (got_q[i] !== 16'(i)) begin
        n_fail++;
        $display("FAIL restart_out[%0d]: got %0d expected %0d", i, $signed(got_q[i]), i);
      end
    end
  endtask

  task automatic test_cfg_ignore();
    start_run(4'd2, 1'b0);
    for (int i = 0; i < 8; i++) feed(16'(-5), 0);
    bus.cfg_passes = 4'd1;
    bus.cfg_relu   = 1'b1;
    bus.cfg_start  = 1'b1;
    step();
    bus.cfg_start  = 1'b0;
    for (int i = 0; i < 24; i++) feed(16'(-5), 0);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_drain_entry: got %b expected 1", bus.out_valid);
    end
    drain(0, 5);
    n_checks++;
    if (got_n !== 16 || !done_at_end) begin
      n_fail++;
      $display("FAIL ign_count_done: got %0d/%b expected 16/1", got_n, done_at_end);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (got_q[i] !== 16'(-10)) begin
        n_fail++;
        $display("FAIL ign_out[%0d]: got %0d expected -10", i, $signed(got_q[i]));
      end
    end
    start_run(4'd0, 1'b0);
    for (int i = 0; i < 16; i++) feed(16'(2 * i), 0);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL k0_drain_entry: got %b expected 1", bus.out_valid);
    end
    drain(0, -1);
    n_checks++;
    if (got_n !== 16) begin
      n_fail++;
      $display("FAIL k0_count: got %0d expected 16", got_n);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (got_q[i] !== 16'(2 * i)) begin
        n_fail++;
        $display("FAIL k0_out[%0d]: got %0d expected %0d", i, $signed(got_q[i]), 2 * i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_pass();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_cfg_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
